// File: rtl/misr_sig_if.sv
// Bus bundle for the misr_sig response compactor: run control, word stream, status.
// MISR_XMASK_EN adds the per-bit xmask input that travels with din.
interface misr_sig_if #(
  parameter int W  = 3,
  parameter int CW = 8
);
  // Handshake: a word transfers on a rising clk edge where din_valid && din_ready;
  // din_ready is high only while a run is active, and otherwise din is dropped.
  logic          start;
  logic [CW-1:0] len;
  logic          din_valid;
  logic [W-1:0]  din;
  logic          din_ready;
  logic          busy;
  logic          done;
  logic [W-1:0]  sig;
  logic          pass;
`ifdef MISR_XMASK_EN
  logic [W-1:0]  xmask;

  modport master (
    output start, len, din_valid, din, xmask,
    input  din_ready, busy, done, sig, pass
  );
  modport slave (
    input  start, len, din_valid, din, xmask,
    output din_ready, busy, done, sig, pass
  );
`else
  modport master (
    output start, len, din_valid, din,
    input  din_ready, busy, done, sig, pass
  );
  modport slave (
    input  start, len, din_valid, din,
    output din_ready, busy, done, sig, pass
  );
`endif
endinterface

// File: rtl/misr_sig.sv
// Multiple-input signature register with a start/len run controller and golden compare.
// Optional `MISR_XMASK_EN: fold din & ~xmask instead of din.
module misr_sig #(
  parameter int           W      = 3,
  parameter logic [W-1:0] POLY   = 3'b011,
  parameter logic [W-1:0] SEED   = 3'b000,
  parameter logic [W-1:0] GOLDEN = 3'b000,
  parameter int           CW     = 8
) (
  input  logic        clk,
  input  logic        rst,
  misr_sig_if.slave   bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sig_q, sig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          pass_q, pass_d;

  logic [W-1:0]  fold_word;
  logic [W-1:0]  sig_fold;
  logic          accept;
  logic          last_word;

`ifdef MISR_XMASK_EN
  assign fold_word = bus.din & ~bus.xmask;
`else
  assign fold_word = bus.din;
`endif

  // Galois-style shift with feedback from the MSB, then XOR in the new word.
  assign sig_fold  = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ fold_word;
  assign accept    = (state_q == S_RUN) && bus.din_valid;
  assign last_word = ((cnt_q + CW'(1)) == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      len_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sig_d  = SEED;
          cnt_d  = '0;
          len_d  = bus.len;
          if (bus.len == '0) begin
            state_d = S_DONE;
            pass_d  = (SEED == GOLDEN);
          end else begin
            state_d = S_RUN;
            pass_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          sig_d = sig_fold;
          cnt_d = cnt_q + CW'(1);
          // Verdict is latched with the last fold so it is valid during the done pulse.
          if (last_word) begin
            state_d = S_DONE;
            pass_d  = (sig_fold == GOLDEN);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == S_RUN);
    bus.din_ready = (state_q == S_RUN);
    bus.done      = (state_q == S_DONE);
    bus.sig       = sig_q;
    bus.pass      = pass_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_misr_sig.sv
// Directed bench for misr_sig: per-cycle vector table plus reset, stall and long-run sequences.
// Masked-word vectors are added when MISR_XMASK_EN is defined.
module tb_misr_sig;

  localparam int W  = 3;
  localparam int CW = 8;

  typedef struct {
    logic         start;
    logic [7:0]   len;
    logic         dv;
    logic [2:0]   din;
    logic [2:0]   xm;
    logic [2:0]   e_sig;
    logic         e_busy;
    logic         e_done;
    logic         e_pass;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;
  vec_t       tbl[$];

  misr_sig_if #(.W(W), .CW(CW)) bus ();

  misr_sig dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] ln, input logic dv,
                       input logic [2:0] d, input logic [2:0] xm);
    bus.start     = st;
    bus.len       = ln;
    bus.din_valid = dv;
    bus.din       = d;
`ifdef MISR_XMASK_EN
    bus.xmask     = xm;
`else
    if (xm != 3'b000) $display("note: xmask ignored in this build");
`endif
  endtask

  function automatic vec_t mk(logic st, logic [7:0] ln, logic dv, logic [2:0] d, logic [2:0] xm,
                              logic [2:0] es, logic eb, logic ed, logic ep);
    vec_t v;
    v.start = st; v.len = ln; v.dv = dv; v.din = d; v.xm = xm;
    v.e_sig = es; v.e_busy = eb; v.e_done = ed; v.e_pass = ep;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [2:0] es, input logic eb,
                               input logic ed, input logic ep);
    chk({tag, " sig"},  {5'd0, bus.sig}, {5'd0, es});
    chk({tag, " busy"}, {7'd0, bus.busy}, {7'd0, eb});
    chk({tag, " rdy"},  {7'd0, bus.din_ready}, {7'd0, eb});
    chk({tag, " done"}, {7'd0, bus.done}, {7'd0, ed});
    chk({tag, " pass"}, {7'd0, bus.pass}, {7'd0, ep});
  endtask

  task automatic build_table();
    // Golden run: LFSR sequence folds back to 000.
    tbl.push_back(mk(1, 7, 0, 3'b000, 3'b000, 3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b100, 3'b000, 3'b100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b001, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b011, 3'b000, 3'b111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b110, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b101, 3'b000, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b010, 3'b000, 3'b000, 0, 1, 1));
    // Word presented during the done cycle is dropped.
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 3'b000, 0, 0, 1));
    // Back-to-back run with third word corrupted 011 -> 111.
    tbl.push_back(mk(1, 7, 0, 3'b000, 3'b000, 3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b100, 3'b000, 3'b100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b001, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 3'b011, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b110, 3'b000, 3'b100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b101, 3'b000, 3'b110, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b010, 3'b000, 3'b101, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 3'b000, 3'b101, 0, 0, 0));
    // len=0: done the cycle after start.
    tbl.push_back(mk(1, 0, 0, 3'b000, 3'b000, 3'b000, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1));
    // Golden run with gaps and stray start pulses mid-run and during done.
    tbl.push_back(mk(1, 7, 0, 3'b000, 3'b000, 3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b100, 3'b000, 3'b100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3'b111, 3'b000, 3'b100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b001, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 3'b101, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b011, 3'b000, 3'b111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 3'b000, 3'b111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 3'b000, 3'b111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(1, 2, 1, 3'b110, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b101, 3'b000, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3'b000, 3'b000, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b010, 3'b000, 3'b000, 0, 1, 1));
    tbl.push_back(mk(1, 5, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 3'b011, 3'b000, 3'b000, 0, 0, 1));
`ifdef MISR_XMASK_EN
    // MSB masked on every word: folds 000,001,011,011,010,001,010.
    tbl.push_back(mk(1, 7, 0, 3'b000, 3'b100, 3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b100, 3'b100, 3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b001, 3'b100, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b011, 3'b100, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b100, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b110, 3'b100, 3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b101, 3'b100, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b010, 3'b100, 3'b000, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1));
`endif
  endtask

  initial begin
    drive(0, 0, 0, 3'b000, 3'b000);
    build_table();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 3'b000, 0, 0, 0);
    chk("reset state", {6'd0, dbg_state}, 8'd0);

    // No start: din traffic is ignored.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 0, i[0], 3'b111, 3'b000);
      @(posedge clk);
      #1;
      check_outputs($sformatf("nostart%0d", i), 3'b000, 0, 0, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].start, tbl[i].len, tbl[i].dv, tbl[i].din, tbl[i].xm);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), tbl[i].e_sig, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_pass);
    end

    // Reset mid-run after 3 words: outputs clear at once, no done afterwards.
    @(negedge clk);
    drive(1, 7, 0, 3'b000, 3'b000);
    @(negedge clk);
    drive(0, 0, 1, 3'b100, 3'b000);
    @(negedge clk);
    drive(0, 0, 1, 3'b001, 3'b000);
    @(negedge clk);
    drive(0, 0, 1, 3'b011, 3'b000);
    @(posedge clk);
    #1;
    check_outputs("pre_rst", 3'b111, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_outputs("mid_rst", 3'b000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 3'b111, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("post_rst%0d", i), 3'b000, 0, 0, 0);
    end

    // Maximum length run: 255 words, busy until the last one.
    @(negedge clk);
    drive(1, 8'd255, 0, 3'b000, 3'b000);
    @(negedge clk);
    drive(0, 0, 1, 3'b000, 3'b000);
    repeat (254) @(posedge clk);
    #1;
    check_outputs("len255_w254", 3'b000, 1, 0, 0);
    @(posedge clk);
    #1;
    check_outputs("len255_end", 3'b000, 0, 1, 1);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 3'b000);
    @(posedge clk);
    #1;
    check_outputs("len255_idle", 3'b000, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
